uart_tx_ctrl: RTL

Transmit-side controller for the UART. Takes bytes from two independent requesters over valid/ready, arbitrates between them round-robin, and builds each start/data/parity/stop frame. Generates the per-bit baud timing and drives the serial line plus activity/done status. It replaces free-running shift sequencing with an explicit, handshaked scheduler.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit controller.
// Contents: parity_t (line encoding of parity_type), tx_state_t (frame
// scheduler states), data width and frame lengths in bit periods.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int FRAME_BITS_PAR   = 11;
    localparam int FRAME_BITS_NOPAR = 10;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit timing for the transmit scheduler.
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active-low
//   load    restart a bit period (frame accept)
//   div     clocks per bit, already forced to >= 1
//   bit_end pulse in the last clock of each div-clock bit period
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt;

    assign bit_end = (cnt == '0);

    // Counts div-1 down to 0; reload value is never below zero since div >= 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else
            cnt <= (load || bit_end) ? div - DIV_W'(1) : cnt - DIV_W'(1);
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: two-requester round-robin UART transmit scheduler.
// Ports:
//   clk, rst              system clock, asynchronous active-low reset
//   baud_div              clocks per bit (0 treated as 1), sampled at accept
//   parity_type           00/11 none, 01 odd, 10 even, sampled at accept
//   req_valid/req_data    per-requester byte offers
//   req_ready             per-requester accept strobe (IDLE only, one-hot)
//   grant_id              requester owning the current/last frame
//   tx                    registered serial line, idle high
//   tx_active             high while a frame is on the line
//   tx_done               pulse in the last clock of the stop bit
module uart_tx_ctrl #(
    parameter int DATA_W = uart_pkg::DATA_W,
    parameter int DIV_W  = 16,
    parameter int N_REQ  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIV_W-1:0]             baud_div,
    input  logic [1:0]                   parity_type,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         grant_id,
    output logic                         tx,
    output logic                         tx_active,
    output logic                         tx_done
);

    import uart_pkg::*;

    localparam int IW = $clog2(DATA_W);

    tx_state_t        state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [DATA_W-1:0] data_q;
    parity_t          par_q;
    logic [DIV_W-1:0] div_q, div_eff, div_sel;
    logic             rr, served, sel, accept, bit_end, par_en, par_bit, tx_d;

    assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
    // While idle the counter must be loaded with the divisor being accepted.
    assign div_sel = (state == IDLE) ? div_eff : div_q;

    // On a tie serve the requester not served last; requester 0 until the first grant.
    assign sel       = (&req_valid) ? (served & ~rr) : req_valid[1];
    assign req_ready = (rst && state == IDLE) ? ({sel, ~sel} & req_valid) : '0;
    assign accept    = |req_ready;

    assign par_en  = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
    assign par_bit = (par_q == PAR_EVEN) ? ^data_q : ~^data_q;
    assign tx_done = (state == STOP) && bit_end;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .div     (div_sel),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d = state;
        idx_d   = idx;
        case (state)
            IDLE:    if (accept) state_d = START;
            START:   if (bit_end) begin
                         state_d = DATA;
                         idx_d   = '0;
                     end
            DATA:    if (bit_end) begin
                         if (idx == IW'(DATA_W - 1))
                             state_d = par_en ? PARITY : STOP;
                         else
                             idx_d = idx + IW'(1);
                     end
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // tx is registered from the next state so the line changes with the state.
        tx_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? data_q[idx_d] :
               (state_d == PARITY) ? par_bit : 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            data_q    <= '0;
            par_q     <= PAR_NONE;
            div_q     <= '0;
            grant_id  <= 1'b0;
            rr        <= 1'b0;
            served    <= 1'b0;
            tx        <= 1'b1;
            tx_active <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            tx        <= tx_d;
            tx_active <= (state_d != IDLE);
            if (accept) begin
                data_q   <= req_data[sel];
                par_q    <= parity_t'(parity_type);
                div_q    <= div_eff;
                grant_id <= sel;
                rr       <= sel;
                served   <= 1'b1;
            end
        end
    end

endmodule
